// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-button synchronizer, debouncer and press/release/long-press pulse generator
// Each button has its own two-flop synchronizer, debounce FSM and saturating hold counter.
module btn_debounce #(
  parameter int NUM_BTNS          = 7,
  parameter int DEBOUNCE_CYCLES   = 1 << 16,
  parameter int LONG_PRESS_CYCLES = 1 << 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_BTNS-1:0] i_btn,
  output logic [NUM_BTNS-1:0] o_btn,
  output logic [NUM_BTNS-1:0] o_press,
  output logic [NUM_BTNS-1:0] o_release,
  output logic [NUM_BTNS-1:0] o_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = {HW{1'b1}};

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [NUM_BTNS-1:0] sync_q1;
  logic [NUM_BTNS-1:0] sync_q2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    logic [1:0]    state;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          long_fired;
    logic          btn_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          sync;
    logic          holding;

    assign sync    = sync_q2[g];
    // A glitch back into RELEASE_WAIT still counts as holding for the long-press timer.
    assign holding = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state      <= IDLE;
        db_cnt     <= '0;
        hold_cnt   <= '0;
        long_fired <= 1'b0;
        btn_q      <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        if (holding && hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        if (holding && !long_fired && hold_cnt >= LONG_LAST) begin
          long_q     <= 1'b1;
          long_fired <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (sync) begin
              state  <= PRESS_WAIT;
              db_cnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync) begin
              state <= IDLE;
            end else if (db_cnt == DB_LAST) begin
              state      <= HELD;
              btn_q      <= 1'b1;
              press_q    <= 1'b1;
              hold_cnt   <= '0;
              long_fired <= 1'b0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          HELD: begin
            if (!sync) begin
              state  <= RELEASE_WAIT;
              db_cnt <= '0;
            end
          end
          default: begin
            if (sync) begin
              state <= HELD;
            end else if (db_cnt == DB_LAST) begin
              state     <= IDLE;
              btn_q     <= 1'b0;
              release_q <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        endcase
      end
    end

    assign o_btn[g]     = btn_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_long[g]    = long_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
// Runs with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32; edge 1 is the first edge after an input change.
module tb_btn_debounce;

  logic       clk;
  logic       rst_n;
  logic [6:0] btn;
  logic [6:0] o_btn;
  logic [6:0] o_press;
  logic [6:0] o_release;
  logic [6:0] o_long;

  int n_assert;
  int n_fail;

  btn_debounce #(
    .NUM_BTNS(7),
    .DEBOUNCE_CYCLES(8),
    .LONG_PRESS_CYCLES(32)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_btn(btn),
    .o_btn(o_btn),
    .o_press(o_press),
    .o_release(o_release),
    .o_long(o_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Step n edges; each pulse output must equal its value only on its given edge, else zero.
  task automatic run(input string name, input int n,
                     input int p_at, input logic [6:0] p_val,
                     input int r_at, input logic [6:0] r_val,
                     input int l_at, input logic [6:0] l_val);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s press e%0d", name, k), o_press, (k == p_at) ? p_val : 7'h00);
      chk($sformatf("%s release e%0d", name, k), o_release, (k == r_at) ? r_val : 7'h00);
      chk($sformatf("%s long e%0d", name, k), o_long, (k == l_at) ? l_val : 7'h00);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    btn      = 7'h00;

    // Reset state
    run("reset", 3, 0, 7'h00, 0, 7'h00, 0, 7'h00);
    chk("reset btn", o_btn, 7'h00);
    rst_n = 1'b1;
    run("idle", 4, 0, 7'h00, 0, 7'h00, 0, 7'h00);

    // Clean press: 20 cycles high then release
    btn = 7'h01;
    run("clean_hi", 20, 11, 7'h01, 0, 7'h00, 0, 7'h00);
    chk("clean btn high", o_btn, 7'h01);
    btn = 7'h00;
    run("clean_lo", 15, 0, 7'h00, 11, 7'h01, 0, 7'h00);
    chk("clean btn low", o_btn, 7'h00);

    // Bounce: toggle every 3 cycles for 30 cycles, then settle high
    for (int p = 0; p < 10; p++) begin
      btn = (p % 2 == 0) ? 7'h01 : 7'h00;
      run("bounce", 3, 0, 7'h00, 0, 7'h00, 0, 7'h00);
    end
    chk("bounce btn", o_btn, 7'h00);
    btn = 7'h01;
    run("bounce_settle", 44, 11, 7'h01, 0, 7'h00, 43, 7'h01);
    chk("long btn", o_btn, 7'h01);

    // 3-cycle low glitch after the long pulse
    btn = 7'h00;
    run("glitch_lo", 3, 0, 7'h00, 0, 7'h00, 0, 7'h00);
    btn = 7'h01;
    run("glitch_hi", 20, 0, 7'h00, 0, 7'h00, 0, 7'h00);
    chk("glitch btn", o_btn, 7'h01);
    btn = 7'h00;
    run("long_rel", 12, 0, 7'h00, 11, 7'h01, 0, 7'h00);
    chk("long rel btn", o_btn, 7'h00);

    // Long hold well past saturation of the hold counter
    btn = 7'h01;
    run("hold3x", 100, 11, 7'h01, 0, 7'h00, 43, 7'h01);
    run("hold_sat", 60, 0, 7'h00, 0, 7'h00, 0, 7'h00);
    chk("hold btn", o_btn, 7'h01);
    btn = 7'h00;
    run("hold_rel", 12, 0, 7'h00, 11, 7'h01, 0, 7'h00);

    // Simultaneous press and release on bits 0 and 6
    btn = 7'b1000001;
    run("simul_hi", 12, 11, 7'b1000001, 0, 7'h00, 0, 7'h00);
    chk("simul btn", o_btn, 7'b1000001);
    btn = 7'h00;
    run("simul_lo", 12, 0, 7'h00, 11, 7'b1000001, 0, 7'h00);
    chk("simul btn low", o_btn, 7'h00);

    // Reset while held: immediate clear, no release, fresh press afterwards
    btn = 7'h01;
    run("rst_pre", 12, 11, 7'h01, 0, 7'h00, 0, 7'h00);
    chk("rst pre btn", o_btn, 7'h01);
    rst_n = 1'b0;
    #1;
    chk("rst async btn", o_btn, 7'h00);
    chk("rst async press", o_press, 7'h00);
    chk("rst async release", o_release, 7'h00);
    run("rst_hold", 2, 0, 7'h00, 0, 7'h00, 0, 7'h00);
    rst_n = 1'b1;
    run("rst_post", 12, 11, 7'h01, 0, 7'h00, 0, 7'h00);
    chk("rst post btn", o_btn, 7'h01);
    btn = 7'h00;
    run("rst_rel", 12, 0, 7'h00, 11, 7'h01, 0, 7'h00);
    chk("rst rel btn", o_btn, 7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
